// File: rtl/keycode_event_queue.sv
// Debounces the SoC keycode PIO and turns level changes into
// press/release/repeat events buffered in a small FWFT FIFO.
module keycode_event_queue #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int DEPTH         = 8
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [7:0]             keycode,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_code,
  output logic [1:0]             evt_type,
  output logic [7:0]             held_code,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(REPEAT_DELAY + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CPRE = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TFIRE = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] TLOAD =
    TW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [AW:0] FULL_N = (AW + 1)'(DEPTH);

  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_REL   = 2'b10;
  localparam logic [1:0] T_REP   = 2'b11;

  typedef enum logic [1:0] {IDLE, HELD, SWAP} state_t;

  state_t        state;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;

  logic          same;
  logic          commit;
  logic          push;
  logic [7:0]    push_code;
  logic [1:0]    push_type;

  logic          stg_vld;
  logic [7:0]    stg_code;
  logic [1:0]    stg_type;

  logic [7:0]    mem_code [DEPTH];
  logic [1:0]    mem_type [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign same = (keycode == cand);

  // Commit is blocked on the SWAP edge; a saturated counter re-fires it next cycle.
  assign commit = same && (cnt >= CPRE) &&
                  (cand != held_code) && (state != SWAP);

  // Select at most one event to push this edge.
  always_comb begin
    push      = 1'b0;
    push_code = '0;
    push_type = '0;
    unique case (1'b1)
      state == SWAP: begin
        push      = 1'b1;
        push_code = held_code;
        push_type = T_PRESS;
      end
      state == IDLE && commit: begin
        push      = 1'b1;
        push_code = cand;
        push_type = T_PRESS;
      end
      state == HELD && commit: begin
        push      = 1'b1;
        push_code = held_code;
        push_type = T_REL;
      end
      state == HELD && !commit && timer == TFIRE: begin
        push      = 1'b1;
        push_code = held_code;
        push_type = T_REP;
      end
      default: ;
    endcase
  end

  // Glitch filter, key-state FSM, repeat timer and event staging.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      timer     <= '0;
      held_code <= '0;
      stg_vld   <= 1'b0;
      stg_code  <= '0;
      stg_type  <= '0;
    end else begin
      if (!same) begin
        cand <= keycode;
        cnt  <= CW'(1);
      end else if (cnt != CMAX) begin
        cnt <= cnt + 1'b1;
      end
      if (commit) held_code <= cand;
      stg_vld  <= push;
      stg_code <= push_code;
      stg_type <= push_type;
      case (state)
        IDLE: begin
          timer <= '0;
          if (commit) state <= HELD;
        end
        HELD: begin
          if (commit) begin
            timer <= '0;
            state <= (cand == 8'h00) ? IDLE : SWAP;
          end else if (timer == TFIRE) begin
            timer <= TLOAD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SWAP: begin
          timer <= '0;
          state <= HELD;
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign full      = (fifo_count == FULL_N);
  assign evt_valid = (fifo_count != '0);
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = stg_vld && (!full || pop);
  assign evt_code  = evt_valid ? mem_code[rd_ptr] : 8'h00;
  assign evt_type  = evt_valid ? mem_type[rd_ptr] : 2'b00;

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_code[i] <= '0;
        mem_type[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_code[wr_ptr] <= stg_code;
        mem_type[wr_ptr] <= stg_type;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (stg_vld && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with
// STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, DEPTH=4.
module tb_keycode_event_queue;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] keycode;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_type;
  logic [7:0] held_code;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  typedef struct {
    logic [7:0] code;
    logic [1:0] typ;
    int         t;
  } ev_t;

  ev_t evq[$];
  int  ecnt = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  keycode_event_queue #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .DEPTH(4)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .keycode(keycode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_type(evt_type),
    .held_code(held_code),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) ecnt <= ecnt + 1;

  always @(negedge clk_clk)
    if (reset_reset_n && evt_valid && evt_ready)
      evq.push_back('{evt_code, evt_type, ecnt});

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic key(input logic [7:0] k, input int n);
    keycode = k;
    tick(n);
  endtask

  task automatic chk_ev(input string tag, input int idx,
                        input logic [7:0] c,
                        input logic [1:0] t);
    if (idx < evq.size()) begin
      check({tag, "_code"}, evq[idx].code, c);
      check({tag, "_type"}, evq[idx].typ, t);
    end else begin
      check({tag, "_present"}, 0, 1);
    end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    keycode       = 8'h00;
    evt_ready     = 1'b1;
    ovf_clr       = 1'b0;
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_type", evt_type, 0);
    check("rst_held", held_code, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    tick(2);
    reset_reset_n = 1'b1;
    tick(5);

    // press, auto-repeat, release
    evq.delete();
    key(8'h1A, 3);
    check("press_held_e3", held_code, 8'h00);
    tick(1);
    check("press_held_e4", held_code, 8'h1A);
    check("press_valid_e4", evt_valid, 0);
    tick(1);
    check("press_valid_e5", evt_valid, 1);
    check("press_code", evt_code, 8'h1A);
    check("press_type", evt_type, 2'b01);
    tick(1);
    check("press_valid_e6", evt_valid, 0);
    check("press_count", fifo_count, 0);
    tick(36);
    key(8'h00, 20);
    check("rep_n", evq.size(), 5);
    chk_ev("rep_press", 0, 8'h1A, 2'b01);
    chk_ev("rep_r1", 1, 8'h1A, 2'b11);
    chk_ev("rep_r2", 2, 8'h1A, 2'b11);
    chk_ev("rep_r3", 3, 8'h1A, 2'b11);
    chk_ev("rep_rel", 4, 8'h1A, 2'b10);
    if (evq.size() == 5) begin
      check("rep_dt1", evq[1].t - evq[0].t, 20);
      check("rep_dt2", evq[2].t - evq[0].t, 28);
      check("rep_dt3", evq[3].t - evq[0].t, 36);
    end

    // glitches
    evq.delete();
    key(8'h04, 3);
    key(8'h00, 10);
    check("glitch_n0", evq.size(), 0);
    check("glitch_held0", held_code, 8'h00);
    key(8'h1A, 10);
    key(8'h00, 2);
    key(8'h1A, 6);
    check("glitch_n1", evq.size(), 1);
    check("glitch_held1", held_code, 8'h1A);

    // swap 0x1A -> 0x16 with consumer stalled
    evt_ready = 1'b0;
    key(8'h16, 3);
    check("swap_held_e3", held_code, 8'h1A);
    tick(1);
    check("swap_held_e4", held_code, 8'h16);
    tick(1);
    check("swap_cnt1", fifo_count, 1);
    check("swap_head_code", evt_code, 8'h1A);
    check("swap_head_type", evt_type, 2'b10);
    tick(1);
    check("swap_cnt2", fifo_count, 2);
    evq.delete();
    evt_ready = 1'b1;
    tick(3);
    check("swap_n", evq.size(), 2);
    chk_ev("swap_rel", 0, 8'h1A, 2'b10);
    chk_ev("swap_press", 1, 8'h16, 2'b01);
    check("swap_cnt0", fifo_count, 0);
    key(8'h00, 7);
    check("swap_n3", evq.size(), 3);
    chk_ev("swap_rel2", 2, 8'h16, 2'b10);
    check("swap_held0", held_code, 8'h00);

    // overflow: six events into a four-entry FIFO
    evt_ready = 1'b0;
    key(8'h11, 4);
    key(8'h12, 4);
    key(8'h13, 4);
    key(8'h00, 4);
    tick(3);
    check("ovf_cnt", fifo_count, 4);
    check("ovf_set", overflow, 1);
    check("ovf_head_code", evt_code, 8'h11);
    check("ovf_head_type", evt_type, 2'b01);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    evq.delete();
    evt_ready = 1'b1;
    tick(5);
    check("ovf_n", evq.size(), 4);
    chk_ev("ovf_e0", 0, 8'h11, 2'b01);
    chk_ev("ovf_e1", 1, 8'h11, 2'b10);
    chk_ev("ovf_e2", 2, 8'h12, 2'b01);
    chk_ev("ovf_e3", 3, 8'h12, 2'b10);
    check("ovf_drained", fifo_count, 0);

    // full FIFO with push and pop on the same edge
    evt_ready = 1'b0;
    evq.delete();
    key(8'h21, 4);
    key(8'h22, 4);
    key(8'h00, 4);
    tick(2);
    check("fpp_cnt_full", fifo_count, 4);
    check("fpp_ovf_pre", overflow, 0);
    key(8'h23, 4);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("fpp_cnt", fifo_count, 4);
    check("fpp_ovf", overflow, 0);
    check("fpp_head_code", evt_code, 8'h21);
    check("fpp_head_type", evt_type, 2'b10);
    check("fpp_n", evq.size(), 1);
    chk_ev("fpp_pop", 0, 8'h21, 2'b01);
    evt_ready = 1'b1;
    tick(5);
    check("fpp_n5", evq.size(), 5);
    chk_ev("fpp_last", 4, 8'h23, 2'b01);
    check("fpp_drained", fifo_count, 0);

    // reset while in SWAP with two entries queued
    evt_ready = 1'b0;
    key(8'h00, 4);
    key(8'h25, 4);
    key(8'h26, 4);
    check("rsw_cnt2", fifo_count, 2);
    check("rsw_held", held_code, 8'h26);
    reset_reset_n = 1'b0;
    #1;
    check("rsw_valid", evt_valid, 0);
    check("rsw_count", fifo_count, 0);
    check("rsw_held0", held_code, 8'h00);
    check("rsw_ovf", overflow, 0);
    keycode = 8'h00;
    tick(2);
    reset_reset_n = 1'b1;
    evt_ready = 1'b1;
    evq.delete();
    tick(10);
    check("rsw_no_ev", evq.size(), 0);
    check("rsw_cnt_after", fifo_count, 0);
    check("rsw_held_after", held_code, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keycode_event_queue.md
Name: keycode_event_queue

Overview:
- Downstream consumer of the SoC keycode PIO output (8-bit USB HID keycode written by the NIOS II software).
- Filters glitches and partial software updates on the keycode, then converts level changes into discrete press, release and auto-repeat events.
- Buffers events in a small first-word-fall-through FIFO with a valid/ready handshake.
- Game logic and the hex/LED status path consume the events.

Parameters:
- STABLE_CYCLES, 16, consecutive identical keycode samples required before a change is committed (>=2)
- REPEAT_DELAY, 25000000, cycles from press commit to first repeat event (0.5 s at 50 MHz)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat events
- DEPTH, 8, FIFO entries (power of 2, >=2)

Ports:
- clk_clk  input  1  system clock, 50 MHz
- reset_reset_n  input  1  asynchronous active-low reset
- keycode  input  8  raw keycode from SoC PIO; 0x00 = no key
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head this cycle
- evt_code  output  8  keycode of head event
- evt_type  output  2  head event type: 01 press, 10 release, 11 repeat
- held_code  output  8  currently committed keycode
- fifo_count  output  $clog2(DEPTH)+1  entries in FIFO
- overflow  output  1  sticky: an event was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async assert, sync release): evt_valid=0, evt_code=0, evt_type=0, held_code=0, fifo_count=0, overflow=0. Internal state: FSM=IDLE, candidate=0, stability counter=0, repeat timer=0, FIFO pointers=0.
- Filter: on each edge, if keycode != candidate, then candidate<=keycode and counter<=1. Otherwise the counter increments, saturating at STABLE_CYCLES.
- Commit: occurs on the edge where the counter reaches STABLE_CYCLES and candidate != held_code. held_code takes the candidate at that edge. Result: a new constant value V is committed on the STABLE_CYCLES-th edge sampling V.
- A value matching held_code never produces an event. Any shorter excursion is discarded.
- FSM states: IDLE (held_code=0), HELD (held_code!=0), SWAP (one-cycle press pending).
- IDLE, commit of B!=0: push press(B); go to HELD; repeat timer<=0.
- HELD (code A), commit of 0: push release(A); go to IDLE.
- HELD (code A), commit of B!=0: push release(A) this edge; go to SWAP. On the next edge, push press(B), go to HELD, timer<=0. The filter keeps running during SWAP. A commit landing exactly on the SWAP edge is deferred by one cycle (the counter stays saturated).
- Repeat (HELD only): the timer increments each cycle.
  - When timer==REPEAT_DELAY-1, push repeat(held_code) and set timer<=REPEAT_DELAY-REPEAT_PERIOD. Subsequent repeats therefore fall every REPEAT_PERIOD cycles.
  - First repeat is pushed REPEAT_DELAY edges after the press push.
  - The timer is held at 0 in IDLE and SWAP.
- FIFO:
  - At most one push per edge.
  - Pop occurs when evt_valid && evt_ready.
  - A push into an empty FIFO makes evt_valid=1 at the following edge. evt_code/evt_type always show the head entry and are stable while evt_valid && !evt_ready.
  - Push while full with no pop: the event is dropped, FIFO contents are unchanged, and overflow<=1.
  - Push while full with a simultaneous pop: both succeed and the count is unchanged.
  - Push and pop on a non-empty, non-full FIFO: the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - While empty, evt_code/evt_type read 0.
- overflow: set has priority over ovf_clr in the same cycle. ovf_clr alone clears it on the next edge.
- Event order in the FIFO equals push order. A release always precedes the press of the replacing key.
- Reset mid-operation (including in SWAP): the pending press is lost, FIFO is emptied, and all outputs return to reset values immediately.

Test Plan:
- Parameters for all scenarios: STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, DEPTH=4.
- Press: evt_ready=1; keycode 0x00->0x1A held. Required: held_code=0x1A on the 4th edge; evt_valid=1 with code 0x1A, type 01 one cycle later for exactly one cycle; fifo_count returns to 0.
- Glitch: keycode=0x04 for 3 cycles, then 0x00. Required: no event, held_code stays 0x00. Also apply 0x1A, then 0x00 for 2 cycles, then 0x1A while held=0x1A. Required: no event.
- Swap: held=0x1A, keycode->0x16, evt_ready=0. Required: FIFO holds release(0x1A) then press(0x16) on consecutive edges; fifo_count=2; evt_ready=1 drains them in that order.
- Auto-repeat: hold 0x1A, evt_ready=1. Required: press at edge P; repeat(0x1A, type 11) pushed at P+20, P+28, P+36. Release 0x1A->0x00 yields release with no further repeats.
- Overflow: evt_ready=0, generate 6 events. Required: fifo_count=4, overflow=1, first 4 events retained in order. Pulse ovf_clr: overflow=0. Full with push+pop in the same cycle: count stays 4, overflow not set.
- Reset: assert reset_reset_n=0 during SWAP with 2 entries queued. Required: immediately evt_valid=0, fifo_count=0, held_code=0. After release with keycode=0x00: no events.
